// File: rtl/life_manager.sv
`default_nettype none
// ============================================================================
// Module      : life_manager
// Description : Player death / respawn sequencer. Counts deaths, freezes the
//               player through the death animation, pulses respawn, and holds
//               an invincibility window afterwards. Timing is in video frames.
// Revision    : 1.0 - initial release
// ============================================================================
module life_manager #(
    parameter int DYING_FRAMES  = 60,
    parameter int INVINC_FRAMES = 120,
    parameter int MAX_DEATHS    = 3
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       frame_tick,
    input  wire logic [1:0] state_in,
    input  wire logic       hit,
    input  wire logic       fell,
    output logic [1:0]      lives,
    output logic            death_pulse,
    output logic            respawn,
    output logic            freeze,
    output logic            invincible
);

    // Counter is sized for the longer of the two frame windows so it never wraps
    localparam int c_max_frames = (DYING_FRAMES > INVINC_FRAMES) ? DYING_FRAMES : INVINC_FRAMES;
    localparam int c_cnt_w      = $clog2(c_max_frames + 1);

    localparam logic [c_cnt_w-1:0] c_dying_last  = c_cnt_w'(DYING_FRAMES);
    localparam logic [c_cnt_w-1:0] c_invinc_last = c_cnt_w'(INVINC_FRAMES);
    localparam logic [1:0]         c_max_lives   = 2'(MAX_DEATHS);
    localparam logic [1:0]         c_game_screen = 2'd1;
    localparam logic [1:0]         c_game_over   = 2'd2;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_alive   = 3'd1;
    localparam logic [2:0] c_st_dying   = 3'd2;
    localparam logic [2:0] c_st_invinc  = 3'd3;
    localparam logic [2:0] c_st_expired = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_lives;
    logic               r_death_pulse;
    logic               r_respawn;
    logic               r_freeze;
    logic               r_invincible;

    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [1:0]         w_lives_inc;
    logic               w_die;

    // Next counter value and saturating death count
    assign w_cnt_inc   = r_cnt + c_cnt_w'(1);
    assign w_lives_inc = (r_lives == c_max_lives) ? r_lives : r_lives + 2'd1;

    // Enemy hits kill only while fully alive; falling kills even when invincible
    assign w_die = ((r_state == c_st_alive) && (hit || fell)) ||
                   ((r_state == c_st_invinc) && fell);

    // Sequencer: screen-state override first, then per-state behaviour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_lives       <= 2'd0;
            r_death_pulse <= 1'b0;
            r_respawn     <= 1'b0;
            r_freeze      <= 1'b0;
            r_invincible  <= 1'b0;
        end else begin
            r_death_pulse <= 1'b0;
            r_respawn     <= 1'b0;
            if (state_in != c_game_screen) begin
                // Leaving gameplay: park in IDLE; GAME_OVER keeps the count
                // visible, START_SCREEN (and the illegal code 3) clears it
                r_state      <= c_st_idle;
                r_cnt        <= '0;
                r_freeze     <= 1'b0;
                r_invincible <= 1'b0;
                if (state_in != c_game_over) begin
                    r_lives <= 2'd0;
                end
            end else if (w_die) begin
                r_state       <= c_st_dying;
                r_lives       <= w_lives_inc;
                r_death_pulse <= 1'b1;
                r_cnt         <= '0;
                r_freeze      <= 1'b1;
                r_invincible  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state      <= c_st_alive;
                        r_respawn    <= 1'b1;
                        r_cnt        <= '0;
                        r_freeze     <= 1'b0;
                        r_invincible <= 1'b0;
                    end
                    c_st_dying: begin
                        if (frame_tick) begin
                            if (w_cnt_inc == c_dying_last) begin
                                r_cnt <= '0;
                                if (r_lives == c_max_lives) begin
                                    // Out of lives: stay frozen until the screen changes
                                    r_state <= c_st_expired;
                                end else begin
                                    r_state      <= c_st_invinc;
                                    r_respawn    <= 1'b1;
                                    r_freeze     <= 1'b0;
                                    r_invincible <= 1'b1;
                                end
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    c_st_invinc: begin
                        if (frame_tick) begin
                            if (w_cnt_inc == c_invinc_last) begin
                                r_state      <= c_st_alive;
                                r_cnt        <= '0;
                                r_invincible <= 1'b0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    c_st_expired: begin
                        r_freeze <= 1'b1;
                    end
                    default: begin
                        // ALIVE without a death: nothing to do
                    end
                endcase
            end
        end
    end

    assign lives       = r_lives;
    assign death_pulse = r_death_pulse;
    assign respawn     = r_respawn;
    assign freeze      = r_freeze;
    assign invincible  = r_invincible;

endmodule
`default_nettype wire

// File: tb/tb_life_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_manager
// Description : Directed self-checking bench for life_manager
//               (DYING_FRAMES=4, INVINC_FRAMES=6, MAX_DEATHS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_manager;

    logic       clk;
    logic       reset_n;
    logic       frame_tick;
    logic [1:0] state_in;
    logic       hit;
    logic       fell;
    logic [1:0] lives;
    logic       death_pulse;
    logic       respawn;
    logic       freeze;
    logic       invincible;

    int n_checks;
    int n_errors;

    life_manager #(
        .DYING_FRAMES (4),
        .INVINC_FRAMES(6),
        .MAX_DEATHS   (3)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .state_in   (state_in),
        .hit        (hit),
        .fell       (fell),
        .lives      (lives),
        .death_pulse(death_pulse),
        .respawn    (respawn),
        .freeze     (freeze),
        .invincible (invincible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; outputs are then sampled 1 ns after the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle frame_tick; returns just after the edge that consumed it
    task automatic frame_pulse();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_lives, input logic e_dp,
                              input logic e_rsp, input logic e_frz, input logic e_inv);
        check({tag, ".lives"},       32'(lives),       32'(e_lives));
        check({tag, ".death_pulse"}, 32'(death_pulse), 32'(e_dp));
        check({tag, ".respawn"},     32'(respawn),     32'(e_rsp));
        check({tag, ".freeze"},      32'(freeze),      32'(e_frz));
        check({tag, ".invincible"},  32'(invincible),  32'(e_inv));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        state_in   = 2'd0;
        hit        = 1'b0;
        fell       = 1'b0;

        // Reset state
        step(3);
        check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(2);
        check_outs("start_screen", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: enter gameplay -> single respawn pulse
        state_in = 2'd1;
        step(1);
        check_outs("enter", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        check_outs("alive", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_outs("alive_hold", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: one-clock hit -> death 1
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check_outs("death1", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("dying1", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            check_outs("dying1_tick", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1);
        end
        frame_pulse();
        check_outs("respawn1", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        check_outs("invinc1", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 3: hit held during invincibility is ignored
        hit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame_pulse();
            check_outs("invinc_hit", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1);
            check_outs("invinc_hit_gap", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            check_outs("invinc_tick", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        // Sixth tick expires invincibility; a coincident hit is still ignored
        hit = 1'b1;
        frame_pulse();
        hit = 1'b0;
        check_outs("invinc_expire", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("alive_again", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Death 2 by hit, then death 3 by falling while invincible
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check_outs("death2", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) frame_pulse();
        check_outs("respawn2", 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        fell = 1'b1;
        step(1);
        fell = 1'b0;
        check_outs("death3_fell", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);

        // 4: third dying window ends in EXPIRED, no respawn
        for (int i = 0; i < 3; i++) frame_pulse();
        check_outs("dying3", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        frame_pulse();
        check_outs("expired", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        hit = 1'b1;
        fell = 1'b1;
        frame_pulse();
        step(2);
        hit = 1'b0;
        fell = 1'b0;
        check_outs("expired_hold", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        state_in = 2'd2;
        step(1);
        check_outs("game_over", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_outs("game_over_hold", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        state_in = 2'd0;
        step(1);
        check_outs("back_to_start", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: simultaneous hit+fell is one death; held hit while dying ignored
        state_in = 2'd1;
        step(1);
        check_outs("enter2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        hit  = 1'b1;
        fell = 1'b1;
        step(1);
        fell = 1'b0;
        check_outs("double_death", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("double_after", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            frame_pulse();
            check_outs("dying_hit_held", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        frame_pulse();
        check_outs("respawn_hit_held", 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        hit = 1'b0;
        check_outs("invinc_hit_held", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 6b: asynchronous reset mid-invincibility acts immediately
        step(1);
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check_outs("reenter", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);

        // 6a: leave gameplay mid-dying (counter = 2)
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check_outs("death_r", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        frame_pulse();
        frame_pulse();
        check_outs("dying_cnt2", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        state_in = 2'd0;
        step(1);
        check_outs("abort_dying", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Illegal code 3 behaves as START_SCREEN: no respawn, no play
        state_in = 2'd3;
        step(2);
        check_outs("illegal_state", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
